// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Low two funct3 bits already encode log2 of the access size in bytes.
  function automatic logic [1:0] f3_size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3, input logic we,
                                    input int unsigned xlen);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = (xlen == 64);
      F3_BU, F3_HU:     ok = !we;
      F3_WU:            ok = !we && (xlen == 64);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment, store strobe/replication, load extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic                      misaligned_o,
  output logic [XLEN/8-1:0]         wstrb_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           rdata_o
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  logic [1:0]      size;
  int unsigned     nbytes;
  logic [XLEN-1:0] sh;

  always_comb begin
    size   = f3_size_log2(funct3_i);
    nbytes = 32'd1 << size;

    misaligned_o = 1'b0;
    for (int unsigned i = 0; i < OW; i++) begin
      if (i < 32'(size) && off_i[i]) misaligned_o = 1'b1;
    end

    wstrb_o = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < nbytes) wstrb_o[i] = 1'b1;
    end
    wstrb_o = wstrb_o << off_i;

    wdata_o = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wdata_o[i*8 +: 8] = wdata_i[(i % nbytes)*8 +: 8];
    end

    sh = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = XLEN'($signed(sh[7:0]));
      F3_H:    rdata_o = XLEN'($signed(sh[15:0]));
      F3_W:    rdata_o = XLEN'($signed(sh[31:0]));
      F3_BU:   rdata_o = XLEN'(sh[7:0]);
      F3_HU:   rdata_o = XLEN'(sh[15:0]);
      F3_WU:   rdata_o = XLEN'(sh[31:0]);
      F3_D:    rdata_o = sh;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_multicycle.sv
// Load/store unit: valid/ready request side, wait-state tolerant memory bus with timeout.
module lsu_multicycle
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  lsu_state_t        state_q;
  logic [OW-1:0]     off_q;
  logic [2:0]        f3_q;
  logic [CW-1:0]     cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [NB-1:0]     mem_wstrb_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;

  logic [OW-1:0]     sel_off;
  logic [2:0]        sel_f3;
  logic              a_misal;
  logic [NB-1:0]     a_wstrb;
  logic [XLEN-1:0]   a_wdata;
  logic [XLEN-1:0]   a_rdata;

  // One aligner serves both phases: request fields in IDLE, latched fields in BUS.
  always_comb begin
    sel_off = (state_q == S_IDLE) ? req_addr[OW-1:0] : off_q;
    sel_f3  = (state_q == S_IDLE) ? req_funct3 : f3_q;
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off_i        (sel_off),
    .funct3_i     (sel_f3),
    .wdata_i      (req_wdata),
    .rdata_i      (mem_rdata),
    .misaligned_o (a_misal),
    .wstrb_o      (a_wstrb),
    .wdata_o      (a_wdata),
    .rdata_o      (a_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      f3_q        <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (!f3_legal(req_funct3, req_we, XLEN) || a_misal) begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end else begin
              off_q       <= req_addr[OW-1:0];
              f3_q        <= req_funct3;
              cnt_q       <= '0;
              mem_we_q    <= req_we;
              mem_addr_q  <= req_addr & ~ADDR_W'(NB - 1);
              mem_wstrb_q <= req_we ? a_wstrb : '0;
              mem_wdata_q <= a_wdata;
              state_q     <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // Ready on the last allowed cycle still completes successfully.
          if (mem_ready) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= mem_we_q ? '0 : a_rdata;
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_valid = (state_q == S_BUS);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
